// File: rtl/mem_word_sequencer_if.sv
// Request/response and byte-memory signals of the multi-byte transfer engine.
interface mem_word_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned SZ_W = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1;

    logic              Start;
    logic              Write;
    logic              Signed;
    logic [SZ_W-1:0]   Size;
    logic [ADDR_W-1:0] BaseAddr;
    logic [DATA_W-1:0] WrData;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] RdData;
    logic [ADDR_W-1:0] Mem_Address;
    logic [7:0]        Mem_Data;
    logic              Mem_WR;
    logic              Mem_CS;
    logic [7:0]        MemOut;

    // Requester and memory side of the engine
    modport master (
        output Start, Write, Signed, Size, BaseAddr, WrData, MemOut,
        input  Busy, Done, RdData, Mem_Address, Mem_Data, Mem_WR, Mem_CS
    );

    // The sequencer itself
    modport slave (
        input  Start, Write, Signed, Size, BaseAddr, WrData, MemOut,
        output Busy, Done, RdData, Mem_Address, Mem_Data, Mem_WR, Mem_CS
    );
endinterface

// File: rtl/mem_word_sequencer.sv
// Sequenced little-endian multi-byte load/store between a byte-wide memory
// and a DATA_W-bit word, one memory access per clock.
module mem_word_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    mem_word_sequencer_if.slave  bus
);
    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned SZ_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [SZ_W-1:0] MAX_SZ = SZ_W'(NB - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    typedef struct packed {
        logic              wr;
        logic              sgn;
        logic [SZ_W-1:0]   size;
        logic [ADDR_W-1:0] base;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [SZ_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] ext;
    logic              sign_bit;

    logic              mem_cs;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    // State and datapath registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, byte assembly and result extension
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        rd_d     = rd_q;
        ext      = '0;
        sign_bit = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    req_d.wr    = bus.Write;
                    req_d.sgn   = bus.Signed;
                    req_d.size  = (bus.Size > MAX_SZ) ? MAX_SZ : bus.Size;
                    req_d.base  = bus.BaseAddr;
                    req_d.wdata = bus.WrData;
                    idx_d       = '0;
                    acc_d       = '0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (!req_q.wr) begin
                    for (int i = 0; i < int'(NB); i++) begin
                        if (idx_q == SZ_W'(i)) acc_d[8*i +: 8] = bus.MemOut;
                    end
                end
                // Top valid byte supplies the sign for the upper bytes
                for (int i = 0; i < int'(NB); i++) begin
                    if (req_q.size == SZ_W'(i)) sign_bit = acc_d[8*i+7];
                end
                for (int i = 0; i < int'(NB); i++) begin
                    ext[8*i +: 8] = (SZ_W'(i) > req_q.size) ? {8{req_q.sgn & sign_bit}}
                                                             : acc_d[8*i +: 8];
                end
                if (idx_q == req_q.size) begin
                    state_d = DONE;
                    if (!req_q.wr) rd_d = ext;
                end else begin
                    idx_d = idx_q + SZ_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Memory strobes decoded from registered state only
    always_comb begin
        mem_cs   = 1'b1;
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (state_q == XFER) begin
            mem_cs   = 1'b0;
            mem_wr   = req_q.wr;
            mem_addr = req_q.base + ADDR_W'(idx_q);
            if (req_q.wr) begin
                for (int i = 0; i < int'(NB); i++) begin
                    if (idx_q == SZ_W'(i)) mem_data = req_q.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.RdData      = rd_q;
    assign bus.Mem_CS      = mem_cs;
    assign bus.Mem_WR      = mem_wr;
    assign bus.Mem_Address = mem_addr;
    assign bus.Mem_Data    = mem_data;
endmodule

// File: tb/tb_mem_word_sequencer.sv
// Bench for mem_word_sequencer: byte memory model, transfer-level reference.
module tb_mem_word_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_word_sequencer_if #(.DATA_W(32), .ADDR_W(16)) bus ();

    mem_word_sequencer #(.DATA_W(32), .ADDR_W(16)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Byte-wide memory seen by the engine
    logic [7:0] mem [65536] = '{default: 8'h00};

    always @(posedge clk) begin
        if (!bus.Mem_CS && bus.Mem_WR) mem[bus.Mem_Address] <= bus.Mem_Data;
    end

    assign bus.MemOut = (!bus.Mem_CS && !bus.Mem_WR) ? mem[bus.Mem_Address] : 8'h00;

    // Reference contents of memory as implied by the issued stores
    logic [7:0]  ref_mem [int unsigned];
    logic [31:0] exp_rd = 32'h0;

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, ".cs"},   64'(bus.Mem_CS),      64'd1);
        check({tag, ".wr"},   64'(bus.Mem_WR),      64'd0);
        check({tag, ".addr"}, 64'(bus.Mem_Address), 64'd0);
        check({tag, ".data"}, 64'(bus.Mem_Data),    64'd0);
    endtask

    // One complete transfer with cycle-by-cycle checking
    task automatic do_xfer(input bit wr, input bit sgn, input int size,
                           input logic [15:0] base, input logic [31:0] wdata);
        int          n;
        int          nb;
        logic [63:0] v;
        logic [15:0] a;
        string       t;
        n = size + 1;
        t = $sformatf("%s%0d@%0h", wr ? "st" : "ld", n, base);
        if (!wr) begin
            v = 64'h0;
            for (int i = 0; i < n; i++) begin
                a = base + 16'(i);
                v = v | (64'(ref_rd(a)) << (8 * i));
            end
            nb = 8 * n;
            if (sgn && v[nb-1]) v = v | ~((64'd1 << nb) - 64'd1);
            exp_rd = v[31:0];
        end else begin
            for (int i = 0; i < n; i++) begin
                a = base + 16'(i);
                ref_mem[int'(a)] = wdata[8*i +: 8];
            end
        end

        @(negedge clk);
        bus.Start    = 1'b1;
        bus.Write    = wr;
        bus.Signed   = sgn;
        bus.Size     = 2'(size);
        bus.BaseAddr = base;
        bus.WrData   = wdata;
        check({t, ".c0.busy"}, 64'(bus.Busy), 64'd0);

        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.Start    = 1'b0;
                bus.Write    = 1'($urandom);
                bus.Signed   = 1'($urandom);
                bus.Size     = 2'($urandom);
                bus.BaseAddr = 16'($urandom);
                bus.WrData   = $urandom;
            end
            a = base + 16'(k);
            check($sformatf("%s.b%0d.cs", t, k),   64'(bus.Mem_CS),      64'd0);
            check($sformatf("%s.b%0d.wr", t, k),   64'(bus.Mem_WR),      64'(wr));
            check($sformatf("%s.b%0d.addr", t, k), 64'(bus.Mem_Address), 64'(a));
            check($sformatf("%s.b%0d.data", t, k), 64'(bus.Mem_Data),
                  wr ? 64'(wdata[8*k +: 8]) : 64'd0);
            check($sformatf("%s.b%0d.busy", t, k), 64'(bus.Busy), 64'd1);
            check($sformatf("%s.b%0d.done", t, k), 64'(bus.Done), 64'd0);
        end

        @(negedge clk);
        check({t, ".done"},    64'(bus.Done),   64'd1);
        check({t, ".dbusy"},   64'(bus.Busy),   64'd1);
        check({t, ".drd"},     64'(bus.RdData), 64'(exp_rd));
        check_idle_bus({t, ".dbus"});

        @(negedge clk);
        check({t, ".idone"},   64'(bus.Done),   64'd0);
        check({t, ".ibusy"},   64'(bus.Busy),   64'd0);
        check({t, ".ird"},     64'(bus.RdData), 64'(exp_rd));

        if (wr) begin
            for (int i = 0; i < n; i++) begin
                a = base + 16'(i);
                check($sformatf("%s.mem%0h", t, a), 64'(mem[a]), 64'(wdata[8*i +: 8]));
            end
        end
    endtask

    initial begin
        logic [15:0] rbase;

        bus.Start    = 1'b0;
        bus.Write    = 1'b0;
        bus.Signed   = 1'b0;
        bus.Size     = 2'd0;
        bus.BaseAddr = 16'h0;
        bus.WrData   = 32'h0;

        // Reset wins over a simultaneous Start
        rst = 1'b1;
        bus.Start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst.busy", 64'(bus.Busy),   64'd0);
        check("rst.done", 64'(bus.Done),   64'd0);
        check("rst.rd",   64'(bus.RdData), 64'd0);
        check_idle_bus("rst");
        bus.Start = 1'b0;
        rst = 1'b0;

        // Directed loads and stores
        do_xfer(1'b1, 1'b0, 3, 16'h0010, 32'h12345678);
        do_xfer(1'b0, 1'b0, 3, 16'h0010, 32'h0);
        check("ld4.value", 64'(bus.RdData), 64'h12345678);
        do_xfer(1'b1, 1'b0, 1, 16'h0030, 32'h00008034);
        do_xfer(1'b0, 1'b1, 1, 16'h0030, 32'h0);
        check("ld2s.value", 64'(bus.RdData), 64'hFFFF8034);
        do_xfer(1'b0, 1'b0, 1, 16'h0030, 32'h0);
        check("ld2u.value", 64'(bus.RdData), 64'h00008034);
        do_xfer(1'b1, 1'b0, 3, 16'h0020, 32'hDEADBEEF);
        check("st4.rd_kept", 64'(bus.RdData), 64'h00008034);
        check("st4.mem", {32'h0, mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]},
              64'hDEADBEEF);
        do_xfer(1'b1, 1'b0, 1, 16'hFFFF, 32'h0000A55A);
        do_xfer(1'b0, 1'b0, 1, 16'hFFFF, 32'h0);
        check("wrap.value", 64'(bus.RdData), 64'h0000A55A);

        // Start held high: one 2-byte load every 4 cycles
        exp_rd = 32'h00008034;
        @(negedge clk);
        bus.Start = 1'b1; bus.Write = 1'b0; bus.Signed = 1'b0;
        bus.Size = 2'd1;  bus.BaseAddr = 16'h0030;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("hold.c%0d.done", c), 64'(bus.Done), 64'((c % 4) == 3));
            check($sformatf("hold.c%0d.busy", c), 64'(bus.Busy), 64'((c % 4) != 0));
            if (c == 12) begin
                check("hold.rd", 64'(bus.RdData), 64'(exp_rd));
                bus.Start = 1'b0;
            end
        end

        // Extra Start pulse during XFER is not queued
        @(negedge clk);
        bus.Start = 1'b1; bus.Size = 2'd3; bus.BaseAddr = 16'h0010;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.Start = (c == 2);
            check($sformatf("pulse.c%0d.done", c), 64'(bus.Done), 64'(c == 5));
            check($sformatf("pulse.c%0d.busy", c), 64'(bus.Busy), 64'(c <= 5));
        end
        check("pulse.rd", 64'(bus.RdData), 64'h12345678);
        exp_rd = 32'h12345678;

        // Reset taken at the edge that writes byte 0 of a 4-byte store
        @(negedge clk);
        bus.Start = 1'b1; bus.Write = 1'b1; bus.Size = 2'd3;
        bus.BaseAddr = 16'h0040; bus.WrData = 32'hCAFEF00D;
        @(negedge clk);
        bus.Start = 1'b0;
        check("mrst.c1.cs", 64'(bus.Mem_CS), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst.busy", 64'(bus.Busy),   64'd0);
        check("mrst.done", 64'(bus.Done),   64'd0);
        check("mrst.rd",   64'(bus.RdData), 64'd0);
        check_idle_bus("mrst");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("mrst.after%0d.done", c), 64'(bus.Done), 64'd0);
            check($sformatf("mrst.after%0d.cs", c),   64'(bus.Mem_CS), 64'd1);
        end
        check("mrst.mem40", 64'(mem[16'h0040]), 64'h0D);
        check("mrst.mem41_43", {40'h0, mem[16'h0043], mem[16'h0042], mem[16'h0041]}, 64'h0);
        ref_mem[32'h40] = 8'h0D;
        exp_rd = 32'h0;

        // Randomised mix of loads and stores against the reference memory
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) rbase = 16'hFFFF - 16'($urandom_range(0, 2));
            else                           rbase = 16'h0100 + 16'($urandom_range(0, 15));
            do_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), rbase, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
